divider_seq: RTL and testbench



---
 rtl/divider_seq_if.sv | 22 ++
 rtl/divider_seq.sv | 154 +++++++++++++++
 tb/tb_divider_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/divider_seq_if.sv
// Operand and result handshake bundle for the sequential divider.
// The master issues operands and accepts results; the slave is the divider.
interface divider_seq_if;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;

    modport master (
        output i_in_valid, i_dividend, i_divisor, i_out_ready,
        input  o_in_ready, o_out_valid, o_quotient, o_remainder
    );

    modport slave (
        input  i_in_valid, i_dividend, i_divisor, i_out_ready,
        output o_in_ready, o_out_valid, o_quotient, o_remainder
    );
endinterface

// File: rtl/divider_seq.sv
// 32-bit unsigned restoring divider, one quotient bit per clock.
// Each trial subtraction runs through a single shared carry-lookahead adder.
module cla (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] g;
    logic [31:0] p;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;
    logic [7:0]  grp_cin;

    assign g = a & b;
    assign p = a ^ b;

    for (genvar k = 0; k < 8; k++) begin : g_grp
        logic [3:0] gg;
        logic [3:0] pp;
        logic [3:0] cc;

        assign gg = g[4*k +: 4];
        assign pp = p[4*k +: 4];

        assign cc[0] = grp_cin[k];
        assign cc[1] = gg[0] | (pp[0] & grp_cin[k]);
        assign cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & grp_cin[k]);
        assign cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                     | (pp[2] & pp[1] & pp[0] & grp_cin[k]);

        assign grp_g[k] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                        | (pp[3] & pp[2] & pp[1] & gg[0]);
        assign grp_p[k] = &pp;

        assign sum[4*k +: 4] = pp ^ cc;
    end

    // Group-level carries resolved from the per-group generate/propagate terms.
    always_comb begin : carry_chain
        logic c;
        c = cin;
        for (int k = 0; k < 8; k++) begin
            grp_cin[k] = c;
            c          = grp_g[k] | (grp_p[k] & c);
        end
        cout = c;
    end
endmodule

module divider_seq (
    input  logic          clk,
    input  logic          rst_n,
    divider_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e      state_q,     state_d;
    logic [4:0]  count_q,     count_d;
    logic [31:0] q_q,         q_d;
    logic [31:0] rem_q,       rem_d;
    logic [31:0] div_q,       div_d;
    logic        in_ready_q,  in_ready_d;
    logic        out_valid_q, out_valid_d;

    logic [32:0] shifted;
    logic [31:0] diff;
    logic        no_borrow;
    logic        ge;

    // The partial remainder's bit 32 is always zero between steps (a set top
    // bit forces a subtraction), so only the low 32 bits are stored.
    assign shifted = {rem_q, q_q[31]};

    cla u_cla (
        .a    (shifted[31:0]),
        .b    (~div_q),
        .cin  (1'b1),
        .sum  (diff),
        .cout (no_borrow)
    );

    // Carry out of a + ~b + 1 is exactly a >= b, so the adder doubles as the comparator.
    assign ge = shifted[32] | no_borrow;

    always_comb begin
        // NOTE: every _d starts from its _q so no branch leaves a value unassigned and infers a latch.
        state_d = state_q;
        count_d = count_q;
        q_d     = q_q;
        rem_d   = rem_q;
        div_d   = div_q;

        unique case (state_q)
            IDLE: begin
                if (bus.i_in_valid && in_ready_q) begin
                    q_d     = bus.i_dividend;
                    div_d   = bus.i_divisor;
                    rem_d   = '0;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                rem_d   = ge ? diff : shifted[31:0];
                q_d     = {q_q[30:0], ge};
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.i_out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            q_q         <= '0;
            rem_q       <= '0;
            div_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            count_q     <= count_d;
            q_q         <= q_d;
            rem_q       <= rem_d;
            div_q       <= div_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.o_in_ready  = in_ready_q;
    assign bus.o_out_valid = out_valid_q;
    assign bus.o_quotient  = q_q;
    assign bus.o_remainder = rem_q;
endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed cases, backpressure, mid-run
// reset and a randomized run, all compared against a scoreboard of model results.
module tb_divider_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    divider_seq_if bus ();

    divider_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] n;
        logic [31:0] d;
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    exp_t   sb[$];
    int     n_pass = 0;
    int     n_total = 0;
    longint cyc = 0;
    longint last_accept = -1;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, got %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

    // Drive one operation; caller is positioned at a negedge. gap_mode: 0 none, 1 >=34, 2 ==34.
    task automatic issue(input logic [31:0] n, input logic [31:0] d, input int gap_mode);
        exp_t e;
        int   w = 0;
        while (!bus.o_in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        n_total++; if (bus.o_in_ready !== 1'b1) $display("FAIL issue_ready: got %b want 1", bus.o_in_ready); else n_pass++;
        bus.i_in_valid = 1'b1;
        bus.i_dividend = n;
        bus.i_divisor  = d;
        @(posedge clk);
        #1;
        if (gap_mode == 1 && last_accept >= 0) begin
            n_total++; if (cyc - last_accept < 34) $display("FAIL issue_gap: got %0d want >=34", cyc - last_accept); else n_pass++;
        end
        if (gap_mode == 2 && last_accept >= 0) begin
            n_total++; if (cyc - last_accept != 34) $display("FAIL issue_gap_min: got %0d want 34", cyc - last_accept); else n_pass++;
        end
        last_accept = cyc;
        e.n = n;
        e.d = d;
        e.q = (d == 32'd0) ? 32'hFFFF_FFFF : n / d;
        e.r = (d == 32'd0) ? n : n % d;
        sb.push_back(e);
        @(negedge clk);
        bus.i_in_valid = 1'b0;
        bus.i_dividend = $urandom;
        bus.i_divisor  = $urandom;
        n_total++; if (bus.o_in_ready !== 1'b0) $display("FAIL accept_ready_drop: got %b want 0", bus.o_in_ready); else n_pass++;
    endtask

    // Wait for the result, hold it for 'stall' cycles, then handshake and compare with the scoreboard.
    task automatic collect(input string name, input int stall, input bit toggle);
        exp_t        e;
        int          lat = 0;
        logic [63:0] recon;
        bus.i_out_ready = (stall == 0);
        while (!bus.o_out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        n_total++; if (lat != 32) $display("FAIL %s_latency: got %0d want 32", name, lat); else n_pass++;
        if (sb.size() == 0) begin
            n_total++; $display("FAIL %s_scoreboard: got empty queue want one entry", name);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < stall; i++) begin
            n_total++; if (bus.o_quotient !== e.q) $display("FAIL %s_hold_q: got %h want %h", name, bus.o_quotient, e.q); else n_pass++;
            n_total++; if (bus.o_remainder !== e.r) $display("FAIL %s_hold_r: got %h want %h", name, bus.o_remainder, e.r); else n_pass++;
            n_total++; if ({bus.o_in_ready, bus.o_out_valid} !== 2'b01) $display("FAIL %s_hold_hs: got %b want 01", name, {bus.o_in_ready, bus.o_out_valid}); else n_pass++;
            if (toggle) begin
                bus.i_in_valid = 1'($urandom);
                bus.i_dividend = $urandom;
                bus.i_divisor  = $urandom;
            end
            @(negedge clk);
        end
        bus.i_in_valid  = 1'b0;
        bus.i_out_ready = 1'b1;
        n_total++; if (bus.o_out_valid !== 1'b1) $display("FAIL %s_valid: got %b want 1", name, bus.o_out_valid); else n_pass++;
        n_total++; if (bus.o_quotient !== e.q) $display("FAIL %s_quotient: got %h want %h (n=%h d=%h)", name, bus.o_quotient, e.q, e.n, e.d); else n_pass++;
        n_total++; if (bus.o_remainder !== e.r) $display("FAIL %s_remainder: got %h want %h (n=%h d=%h)", name, bus.o_remainder, e.r, e.n, e.d); else n_pass++;
        if (e.d != 32'd0) begin
            recon = {32'd0, bus.o_quotient} * {32'd0, e.d} + {32'd0, bus.o_remainder};
            n_total++; if (recon !== {32'd0, e.n} || bus.o_remainder >= e.d) $display("FAIL %s_identity: got q*d+r=%h r=%h want %h r<%h", name, recon, bus.o_remainder, e.n, e.d); else n_pass++;
        end
        @(negedge clk);
        n_total++; if ({bus.o_in_ready, bus.o_out_valid} !== 2'b10) $display("FAIL %s_after_hs: got %b want 10", name, {bus.o_in_ready, bus.o_out_valid}); else n_pass++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_total++; if (bus.o_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.o_in_ready); else n_pass++;
        n_total++; if (bus.o_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.o_out_valid); else n_pass++;
        n_total++; if (bus.o_quotient !== 32'd0) $display("FAIL reset_quotient: got %h want 0", bus.o_quotient); else n_pass++;
        n_total++; if (bus.o_remainder !== 32'd0) $display("FAIL reset_remainder: got %h want 0", bus.o_remainder); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++; if ({bus.o_in_ready, bus.o_out_valid} !== 2'b10) $display("FAIL reset_release: got %b want 10", {bus.o_in_ready, bus.o_out_valid}); else n_pass++;
    endtask

    task automatic test_basic();
        issue(32'd100, 32'd7, 0);
        collect("div_100_7", 0, 1'b0);
    endtask

    task automatic test_edges();
        issue(32'hFFFF_FFFF, 32'd1, 0);
        collect("max_by_1", 0, 1'b0);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        collect("max_by_max", 0, 1'b0);
        issue(32'd5, 32'd9, 0);
        collect("small_by_large", 0, 1'b0);
        issue(32'h1234_5678, 32'd0, 0);
        collect("div_by_zero", 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        issue(32'd1000, 32'd33, 0);
        collect("b2b_first", 0, 1'b0);
        issue(32'hDEAD_BEEF, 32'h0001_0001, 2);
        collect("b2b_second", 0, 1'b0);
    endtask

    task automatic test_backpressure();
        issue(32'h8765_4321, 32'd1234, 0);
        collect("backpressure", 10, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        int seen_valid = 0;
        issue(32'hCAFE_F00D, 32'd3, 0);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++; if ({bus.o_in_ready, bus.o_out_valid} !== 2'b10) $display("FAIL midrun_reset_hs: got %b want 10", {bus.o_in_ready, bus.o_out_valid}); else n_pass++;
        n_total++; if ({bus.o_quotient, bus.o_remainder} !== 64'd0) $display("FAIL midrun_reset_data: got %h want 0", {bus.o_quotient, bus.o_remainder}); else n_pass++;
        sb.delete();
        last_accept = -1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.o_out_valid) seen_valid++;
        end
        n_total++; if (seen_valid != 0) $display("FAIL midrun_discard: got %0d valid cycles want 0", seen_valid); else n_pass++;
        issue(32'd50, 32'd5, 0);
        collect("after_reset_50_5", 0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] n;
        logic [31:0] d;
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 7))
                0:       d = 32'd0;
                1:       d = 32'd1;
                2:       d = $urandom_range(2, 15);
                3:       d = $urandom >> $urandom_range(0, 31);
                default: d = $urandom;
            endcase
            n = ($urandom_range(0, 3) == 0) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
            issue(n, d, 1);
            collect("random", $urandom_range(0, 3), 1'b1);
        end
    endtask

    initial begin
        bus.i_in_valid  = 1'b0;
        bus.i_dividend  = '0;
        bus.i_divisor   = '0;
        bus.i_out_ready = 1'b0;
        test_reset();
        test_basic();
        test_edges();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
